serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter BYTES, default 4, meaning operand width in bytes (BYTES >= 1; W = BYTES*8).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operands present.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  W  minuend.
REQ-007 SHALL have port b  input  W  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow-in.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port q  output  W  difference a - b - bin mod 2^W.
REQ-012 SHALL have port bout  output  1  borrow-out, 1 when a < b + bin unsigned.
REQ-013 SHALL have port zero  output  1  q == 0.
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 SHALL accept on the edge where in_valid && in_ready, capturing a, b, bin into internal registers, clearing byte index to 0, and entering RUN.
REQ-018 SHALL, in RUN, process one byte per clock, least significant first: byte i = a_i - b_i - borrow, with borrow for byte 0 = captured bin, then the byte's borrow-out.
REQ-019 SHALL write each result byte into q[i*8+7:i*8] on the edge it is processed.
REQ-020 SHALL enter DONE on the edge processing byte BYTES-1, so out_valid rises exactly BYTES clocks after the accept edge.
REQ-021 SHALL set bout to the borrow out of byte BYTES-1, zero to (full q == 0), and ovf to (a[W-1] != b[W-1]) && (q[W-1] != a[W-1]), all valid when out_valid = 1.
REQ-022 SHALL hold q, bout, zero, ovf, and out_valid stable in DONE while out_ready = 0.
REQ-023 SHALL return to IDLE on the edge where out_valid && out_ready; q and flags retain their values until the next accept.
REQ-024 SHALL ignore a, b, bin, and in_valid outside the accept edge; input changes during RUN/DONE do not affect the result.
REQ-025 SHALL support BYTES = 1: accept edge to DONE takes 1 clock.
REQ-026 SHALL never overlap operations; maximum throughput is one result per BYTES+2 clocks.

Reset
REQ-027 SHALL, when rst = 1 at a rising edge, enter IDLE; clear q, bout, zero-register source, ovf, byte index, and captured operands to 0; drive out_valid = 0 and in_ready = 1 from the following cycle.
REQ-028 SHALL give rst priority over every handshake; reset during RUN or DONE discards the operation with no out_valid pulse.
REQ-029 SHALL present zero = 1 after reset, since q = 0.

Structure
REQ-030 SHALL place the state encoding (IDLE/RUN/DONE) and the byte width constant 8 in a shared package used by the team's arithmetic blocks.
REQ-031 SHALL instantiate one combinational sub-module, byte_sub, with 8-bit x, y, borrow-in and 8-bit difference and borrow-out, used once per clock on the selected byte.
REQ-032 SHALL size the byte index as clog2(BYTES), minimum 1 bit.

Verification (BYTES = 4)
REQ-033 SHALL check a=0x00000005, b=0x00000003, bin=0 -> q=0x00000002, bout=0, zero=0, ovf=0; out_valid exactly 4 clocks after accept.
REQ-034 SHALL check a=0x00010000, b=0x00000001, bin=0 -> q=0x0000FFFF, bout=0 (borrow across two bytes); and a=0, b=0, bin=1 -> q=0xFFFFFFFF, bout=1.
REQ-035 SHALL check a=b=0x12345678, bin=0 -> q=0, zero=1, bout=0; and a=0x80000000, b=1 -> q=0x7FFFFFFF, ovf=1, bout=0.
REQ-036 SHALL check out_ready held 0 for 5 clocks in DONE -> outputs stable, in_ready=0; a, b changed mid-RUN -> result unchanged.
REQ-037 SHALL check rst asserted on the 2nd RUN clock -> next cycle IDLE, in_ready=1, out_valid=0, q=0; a fresh operation then completes correctly.
REQ-038 SHALL check back-to-back operations with in_valid held high -> second accept occurs the clock after the first out handshake, and results match a reference model over 1000 random operand sets including bin.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared constants and state encoding for the byte-serial arithmetic blocks.
package serial_subtractor_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arith_state_t;

    // Byte-index width; a single-byte operand still gets a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_byte_sub.sv
// One byte of a ripple subtraction: d = x - y - bin, with borrow out.
module byte_sub
    import serial_subtractor_pkg::*;
(
    input  logic [BYTE_W-1:0] x,
    input  logic [BYTE_W-1:0] y,
    input  logic              bin,
    output logic [BYTE_W-1:0] d_c,
    output logic              bout_c
);

    localparam int unsigned EXT_W = BYTE_W + 1;

    logic [EXT_W-1:0] diff_wide;

    // Extra MSB of the widened difference is the borrow.
    always_comb begin
        diff_wide = {1'b0, x} - {1'b0, y} - EXT_W'(bin);
    end

    assign d_c    = diff_wide[BYTE_W-1:0];
    assign bout_c = diff_wide[BYTE_W];

endmodule

// File: rtl/serial_subtractor.sv
// Byte-serial subtractor: q = a - b - bin, one byte per clock, LSB first,
// with valid/ready handshakes on both sides and borrow/zero/overflow flags.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned BYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTES*BYTE_W-1:0]  a,
    input  logic [BYTES*BYTE_W-1:0]  b,
    input  logic                     bin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTES*BYTE_W-1:0]  q,
    output logic                     bout,
    output logic                     zero,
    output logic                     ovf
);

    localparam int unsigned IDX_W = idx_width(BYTES);
    localparam int unsigned LAST  = BYTES - 1;

    arith_state_t state;
    arith_state_t state_nx;

    logic [BYTES-1:0][BYTE_W-1:0] a_r;
    logic [BYTES-1:0][BYTE_W-1:0] b_r;
    logic [BYTES-1:0][BYTE_W-1:0] q_r;
    logic [BYTES-1:0][BYTE_W-1:0] q_nx;
    logic                         borrow_r;
    logic [IDX_W-1:0]             idx;

    logic                         accept;
    logic                         step;
    logic                         last;
    logic [BYTE_W-1:0]            a_byte;
    logic [BYTE_W-1:0]            b_byte;
    logic [BYTE_W-1:0]            d_byte;
    logic                         borrow_byte;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and per-cycle control
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        last     = (idx == IDX_W'(LAST));
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Handshake flags are flopped from the next state so they track the FSM exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);
        end
    end

    always_comb begin
        a_byte = a_r[idx];
        b_byte = b_r[idx];
    end

    byte_sub u_byte_sub (
        .x      (a_byte),
        .y      (b_byte),
        .bin    (borrow_r),
        .d_c    (d_byte),
        .bout_c (borrow_byte)
    );

    // Result with the current byte merged in, used for the zero flag on the last byte.
    always_comb begin
        q_nx      = q_r;
        q_nx[idx] = d_byte;
    end

    // Operand capture, byte ripple and final flag update
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            q_r      <= '0;
            borrow_r <= 1'b0;
            idx      <= '0;
            bout     <= 1'b0;
            zero     <= 1'b1;
            ovf      <= 1'b0;
        end else if (accept) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= bin;
            idx      <= '0;
        end else if (step) begin
            q_r      <= q_nx;
            borrow_r <= borrow_byte;
            idx      <= last ? '0 : idx + IDX_W'(1);
            if (last) begin
                bout <= borrow_byte;
                zero <= (q_nx == '0);
                ovf  <= (a_r[LAST][BYTE_W-1] != b_r[LAST][BYTE_W-1]) &&
                        (d_byte[BYTE_W-1] != a_r[LAST][BYTE_W-1]);
            end
        end
    end

    assign q = q_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector and randomized back-to-back bench for serial_subtractor (BYTES = 4).
module tb_serial_subtractor;

    localparam int unsigned BYTES = 4;
    localparam int unsigned W     = BYTES * 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] q;
    logic         bout;
    logic         zero;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] q;
        logic         bout;
        logic         zero;
        logic         ovf;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    serial_subtractor #(.BYTES(BYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        vec_t        v;
        logic [W:0]  t;
        t      = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
        v.a    = ma;
        v.b    = mb;
        v.bin  = mbin;
        v.q    = t[W-1:0];
        v.bout = t[W];
        v.zero = (t[W-1:0] == '0);
        v.ovf  = (ma[W-1] != mb[W-1]) && (t[W-1] != ma[W-1]);
        return v;
    endfunction

    task automatic wait_idle(output int waits);
        waits = 0;
        while (in_ready !== 1'b1 && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 20) check("idle_timeout", 64'(in_ready), 64'(1));
    endtask

    // Present operands for one accept edge, then scramble the inputs.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                            input logic keep_valid, output int waits);
        wait_idle(waits);
        a        = ta;
        b        = tb_;
        bin      = tbin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = keep_valid;
        a        = $urandom;
        b        = $urandom;
        bin      = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat);
        check({tag, ".latency"},  64'(lat),       64'(BYTES));
        check({tag, ".q"},        64'(q),         64'(v.q));
        check({tag, ".bout"},     64'(bout),      64'(v.bout));
        check({tag, ".zero"},     64'(zero),      64'(v.zero));
        check({tag, ".ovf"},      64'(ovf),       64'(v.ovf));
        check({tag, ".in_ready"}, 64'(in_ready),  64'(0));
    endtask

    task automatic handshake(input string tag, input logic keep_ready);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = keep_ready;
        check({tag, ".hs_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, ".hs_in_ready"},  64'(in_ready),  64'(1));
    endtask

    initial begin
        int   lat;
        int   waits;
        vec_t v;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset.in_ready",  64'(in_ready),  64'(1));
        check("reset.out_valid", 64'(out_valid), 64'(0));
        check("reset.q",         64'(q),         64'(0));
        check("reset.bout",      64'(bout),      64'(0));
        check("reset.zero",      64'(zero),      64'(1));
        check("reset.ovf",       64'(ovf),       64'(0));

        //          a              b              bin   q              bout  zero  ovf
        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, waits);
            wait_done(lat);
            check_result($sformatf("vec%0d", i), vecs[i], lat);
            handshake($sformatf("vec%0d", i), 1'b0);
        end

        // Consumer stall: outputs hold while in_valid is also asserted.
        start_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, waits);
        wait_done(lat);
        check_result("stall", vecs[0], lat);
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("stall.out_valid", 64'(out_valid), 64'(1));
            check("stall.in_ready",  64'(in_ready),  64'(0));
            check("stall.q",         64'(q),         64'(32'h0000_0002));
            check("stall.flags",     64'({bout, zero, ovf}), 64'(3'b000));
        end
        in_valid = 1'b0;
        handshake("stall", 1'b0);
        check("post_hs.q_retained", 64'(q), 64'(32'h0000_0002));

        // Reset on the second RUN clock discards the operation.
        start_op(32'h0001_0000, 32'h0000_0001, 1'b0, 1'b0, waits);
        @(posedge clk); #1;
        check("midrun.partial_q", 64'(q), 64'(32'h0000_00FF));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun.in_ready",  64'(in_ready),  64'(1));
        check("midrun.out_valid", 64'(out_valid), 64'(0));
        check("midrun.q",         64'(q),         64'(0));
        check("midrun.zero",      64'(zero),      64'(1));
        repeat (6) begin
            @(posedge clk); #1;
            check("midrun.no_valid", 64'(out_valid), 64'(0));
        end
        start_op(vecs[1].a, vecs[1].b, vecs[1].bin, 1'b0, waits);
        wait_done(lat);
        check_result("after_rst", vecs[1], lat);
        handshake("after_rst", 1'b0);

        // Back-to-back random operations with in_valid and out_ready held high.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra   = $urandom;
            rb   = (i % 10 == 0) ? ra : W'($urandom);
            rbin = 1'($urandom);
            v    = model(ra, rb, rbin);
            start_op(ra, rb, rbin, 1'b1, waits);
            check("b2b.accept_wait", 64'(waits), 64'(0));
            wait_done(lat);
            check_result("b2b", v, lat);
            handshake("b2b", 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
